// File: rtl/apb_biu_ws_if.sv
// APB4 slave-side bundle plus the request/acknowledge link to the register file.
// The slave modport is the bus interface unit; the master modport is whatever drives it.
interface apb_biu_ws_if #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32
);
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [APB_ADDR_WIDTH-1:0]     paddr;
    logic [APB_DATA_WIDTH-1:0]     pwdata;
    logic [APB_DATA_WIDTH/8-1:0]   pstrb;
    logic [APB_DATA_WIDTH-1:0]     prdata;
    logic                          pready;
    logic                          pslverr;
    logic                          req;
    logic                          req_wr;
    logic [APB_ADDR_WIDTH-3:0]     reg_addr;
    logic [3:0]                    byte_en;
    logic [31:0]                   ipwdata;
    logic [31:0]                   iprdata;
    logic                          ack;
    logic                          err;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, iprdata, ack, err,
        output prdata, pready, pslverr, req, req_wr, reg_addr, byte_en, ipwdata
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, iprdata, ack, err,
        input  prdata, pready, pslverr, req, req_wr, reg_addr, byte_en, ipwdata
    );
endinterface

// File: rtl/apb_biu_ws.sv
// APB4 slave bus interface: turns each setup phase into one req/ack regfile transaction,
// with byte-lane steering, registered read data and a watchdog against a silent regfile.
module apb_biu_ws #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 15
) (
    input  logic          pclk,
    input  logic          preset,
    apb_biu_ws_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t                      state_q, state_d;
    logic [7:0]                  timer_q, timer_d;
    logic                        req_q, req_d;
    logic                        req_wr_q, req_wr_d;
    logic [APB_ADDR_WIDTH-3:0]   reg_addr_q, reg_addr_d;
    logic [3:0]                  byte_en_q, byte_en_d;
    logic [31:0]                 ipwdata_q, ipwdata_d;
    logic [1:0]                  lane_off_q, lane_off_d;
    logic [APB_DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                        pready_q, pready_d;
    logic                        pslverr_q, pslverr_d;

    logic [1:0]                  lane_off;
    logic [3:0]                  rd_mask;
    logic [3:0]                  wr_mask;
    logic [31:0]                 pwdata_ext;
    logic [31:0]                 rd_shift;
    logic                        timeout_hit;

    // Lane offset and lane masks depend only on the bus width, so pick the decode at elaboration.
    generate
        if (APB_DATA_WIDTH == 8) begin : g_w8
            assign lane_off = bus.paddr[1:0];
            assign rd_mask  = 4'b0001 << lane_off;
            assign wr_mask  = {3'b000, bus.pstrb[0]} << lane_off;
        end else if (APB_DATA_WIDTH == 16) begin : g_w16
            assign lane_off = {bus.paddr[1], 1'b0};
            assign rd_mask  = 4'b0011 << lane_off;
            assign wr_mask  = {2'b00, bus.pstrb} << lane_off;
        end else begin : g_w32
            assign lane_off = 2'b00;
            assign rd_mask  = 4'b1111;
            assign wr_mask  = bus.pstrb;
        end
    endgenerate

    assign pwdata_ext  = 32'(bus.pwdata);
    assign rd_shift    = bus.iprdata >> {lane_off_q, 3'b000};
    // Fires in the TIMEOUT-th consecutive REQ cycle without an acknowledge.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, timer_q} + 9'd1) == TIMEOUT_W);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            byte_en_q  <= '0;
            ipwdata_q  <= '0;
            lane_off_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            req_q      <= req_d;
            req_wr_q   <= req_wr_d;
            reg_addr_q <= reg_addr_d;
            byte_en_q  <= byte_en_d;
            ipwdata_q  <= ipwdata_d;
            lane_off_q <= lane_off_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        req_d      = req_q;
        req_wr_d   = req_wr_q;
        reg_addr_d = reg_addr_q;
        byte_en_d  = byte_en_q;
        ipwdata_d  = ipwdata_q;
        lane_off_d = lane_off_q;
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (bus.psel && !bus.penable) begin
                    reg_addr_d = bus.paddr[APB_ADDR_WIDTH-1:2];
                    req_wr_d   = bus.pwrite;
                    byte_en_d  = bus.pwrite ? wr_mask : rd_mask;
                    ipwdata_d  = pwdata_ext << {lane_off, 3'b000};
                    lane_off_d = lane_off;
                    // A write with no strobed lane has nothing to do in the regfile.
                    if (bus.pwrite && (wr_mask == 4'b0000)) begin
                        pready_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        req_d    = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                timer_d = timer_q + 8'd1;
                if (bus.ack) begin
                    req_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = bus.err;
                    if (!req_wr_q) begin
                        prdata_d = rd_shift[APB_DATA_WIDTH-1:0];
                    end
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.prdata   = prdata_q;
    assign bus.pready   = pready_q;
    assign bus.pslverr  = pslverr_q;
    assign bus.req      = req_q;
    assign bus.req_wr   = req_wr_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.byte_en  = byte_en_q;
    assign bus.ipwdata  = ipwdata_q;
endmodule
